// File: rtl/reset_seq_pkg.sv
// Shared types and default constants for the staged reset sequencer.
// Imported by the sequencer top and its timer.
package reset_seq_pkg;

  localparam int DEF_NUM_STAGES     = 4;
  localparam int DEF_GAP_CYCLES     = 16;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_WAIT,
    S_DONE,
    S_ERROR
  } seq_state_e;

  // Wide enough for the larger of the two loads; the timer never wraps.
  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter shared by the gap and timeout phases.
// Saturates at zero; o_expired is high while the count is zero.
module seq_timer #(
  parameter int W = 11
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         i_start,
  input  logic [W-1:0] i_load,
  output logic         o_expired
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= i_load;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Releases downstream reset domains one at a time, waiting for each
// stage to acknowledge before moving on; any timeout or loss is terminal.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES     = DEF_NUM_STAGES,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic [NUM_STAGES-1:0]         stage_ready,
  output logic [NUM_STAGES-1:0]         stage_rst,
  output logic                          seq_done,
  output logic                          seq_error,
  output logic [$clog2(NUM_STAGES)-1:0] err_stage
);

  localparam int IW = $clog2(NUM_STAGES);
  localparam int CW = cnt_width(GAP_CYCLES, TIMEOUT_CYCLES);

  seq_state_e            r_state;
  seq_state_e            w_state_nx;
  logic [IW-1:0]         r_idx;
  logic [IW-1:0]         w_idx_nx;
  logic [NUM_STAGES-1:0] r_stage_rst;
  logic [NUM_STAGES-1:0] w_rst_nx;
  logic                  r_done;
  logic                  w_done_nx;
  logic                  r_error;
  logic                  w_error_nx;
  logic [IW-1:0]         r_err_stage;
  logic [IW-1:0]         w_err_stage_nx;

  logic                  w_tmr_start;
  logic [CW-1:0]         w_tmr_load;
  logic                  w_tmr_expired;
  logic                  w_last;
  logic [IW-1:0]         w_drop_idx;

  seq_timer #(
    .W (CW)
  ) u_timer (
    .CLK       (CLK),
    .reset     (reset),
    .i_start   (w_tmr_start),
    .i_load    (w_tmr_load),
    .o_expired (w_tmr_expired)
  );

  assign w_last = (r_idx == IW'(NUM_STAGES - 1));

  always_comb begin
    w_drop_idx = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (!stage_ready[i]) begin
        w_drop_idx = IW'(i);
      end
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_idx_nx       = r_idx;
    w_rst_nx       = r_stage_rst;
    w_done_nx      = r_done;
    w_error_nx     = r_error;
    w_err_stage_nx = r_err_stage;
    w_tmr_start    = 1'b0;
    w_tmr_load     = '0;
    unique case (r_state)
      S_IDLE: begin
        w_state_nx  = S_GAP;
        w_idx_nx    = '0;
        w_tmr_start = 1'b1;
        w_tmr_load  = CW'(GAP_CYCLES);
      end
      S_GAP: begin
        if (w_tmr_expired) begin
          w_state_nx      = S_WAIT;
          w_rst_nx[r_idx] = 1'b0;
          w_tmr_start     = 1'b1;
          w_tmr_load      = CW'(TIMEOUT_CYCLES - 1);
        end
      end
      S_WAIT: begin
        // Ready is checked before expiry so a last-cycle ack still passes.
        if (stage_ready[r_idx]) begin
          if (w_last) begin
            w_state_nx = S_DONE;
            w_done_nx  = 1'b1;
          end else begin
            w_state_nx  = S_GAP;
            w_idx_nx    = r_idx + IW'(1);
            w_tmr_start = 1'b1;
            w_tmr_load  = CW'(GAP_CYCLES);
          end
        end else if (w_tmr_expired) begin
          w_state_nx     = S_ERROR;
          w_rst_nx       = '1;
          w_done_nx      = 1'b0;
          w_error_nx     = 1'b1;
          w_err_stage_nx = r_idx;
        end
      end
      S_DONE: begin
        if (!(&stage_ready)) begin
          w_state_nx     = S_ERROR;
          w_rst_nx       = '1;
          w_done_nx      = 1'b0;
          w_error_nx     = 1'b1;
          w_err_stage_nx = w_drop_idx;
        end
      end
      S_ERROR: begin
        w_state_nx = S_ERROR;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_stage_rst <= '1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_err_stage <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_idx       <= w_idx_nx;
      r_stage_rst <= w_rst_nx;
      r_done      <= w_done_nx;
      r_error     <= w_error_nx;
      r_err_stage <= w_err_stage_nx;
    end
  end

  assign stage_rst = r_stage_rst;
  assign seq_done  = r_done;
  assign seq_error = r_error;
  assign err_stage = r_err_stage;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: planned output changes are queued by a timing model,
// a negedge monitor pops and compares each observed output change.
module tb_reset_sequencer;

  localparam int NS    = 4;
  localparam int G     = 16;
  localparam int T     = 1024;
  localparam int NEVER = 100000;
  localparam int BIG   = 1000000;

  typedef struct {
    int         e;
    logic [3:0] rst;
    logic       done;
    logic       err;
    logic [1:0] es;
  } ev_t;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] stage_ready = 4'h0;
  logic [3:0] stage_rst;
  logic       seq_done;
  logic       seq_error;
  logic [1:0] err_stage;

  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  bit  mon_en = 1'b0;
  ev_t q[$];
  ev_t mx;
  int  rise[NS];

  logic [3:0] m_rst = 4'hF;
  logic       m_done = 1'b0;
  logic       m_err = 1'b0;
  logic [1:0] m_es = 2'd0;

  logic [3:0] p_rst = 4'hF;
  logic       p_done = 1'b0;
  logic       p_err = 1'b0;
  logic [1:0] p_es = 2'd0;

  reset_sequencer #(
    .NUM_STAGES     (4),
    .GAP_CYCLES     (16),
    .TIMEOUT_CYCLES (1024)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .stage_ready (stage_ready),
    .stage_rst   (stage_rst),
    .seq_done    (seq_done),
    .seq_error   (seq_error),
    .err_stage   (err_stage)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (mon_en) begin
      if (stage_rst !== p_rst || seq_done !== p_done ||
          seq_error !== p_err || err_stage !== p_es) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change edge=%0d got rst=%b done=%b err=%b es=%0d",
                   cyc, stage_rst, seq_done, seq_error, err_stage);
        end else begin
          mx = q.pop_front();
          if (mx.e != cyc || mx.rst !== stage_rst || mx.done !== seq_done ||
              mx.err !== seq_error || mx.es !== err_stage) begin
            failures++;
            $display("FAIL event got edge=%0d rst=%b done=%b err=%b es=%0d exp edge=%0d rst=%b done=%b err=%b es=%0d",
                     cyc, stage_rst, seq_done, seq_error, err_stage,
                     mx.e, mx.rst, mx.done, mx.err, mx.es);
          end
        end
        p_rst  = stage_rst;
        p_done = seq_done;
        p_err  = seq_error;
        p_es   = err_stage;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    for (int i = 0; i < NS; i++) begin
      if (cyc == rise[i]) stage_ready[i] = 1'b1;
    end
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic expect_at(input int e, input logic [3:0] r, input logic d,
                           input logic er, input logic [1:0] es);
    ev_t x;
    if (r !== m_rst || d !== m_done || er !== m_err || es !== m_es) begin
      x.e = e; x.rst = r; x.done = d; x.err = er; x.es = es;
      q.push_back(x);
      m_rst = r; m_done = d; m_err = er; m_es = es;
    end
  endtask

  // Timing model: release i at (previous ack or reset-low edge) + G + 1,
  // ack at release + delay, timeout T WAIT cycles after release.
  task automatic plan(input int k, input int d[NS], input int cut,
                      output int fin);
    logic [3:0] r;
    int t;
    int rel;
    r = 4'hF;
    t = k;
    fin = k;
    for (int i = 0; i < NS; i++) begin
      rel = t + G + 1;
      if (rel >= cut) return;
      r[i] = 1'b0;
      expect_at(rel, r, 1'b0, 1'b0, 2'd0);
      fin = rel;
      if (d[i] > T) begin
        if (rel + T < cut) begin
          expect_at(rel + T, 4'hF, 1'b0, 1'b1, 2'(i));
          fin = rel + T;
        end
        return;
      end
      if (rel + d[i] - 1 < cut) rise[i] = rel + d[i] - 1;
      t = rel + d[i];
    end
    if (t < cut) begin
      expect_at(t, r, 1'b1, 1'b0, 2'd0);
      fin = t;
    end
  endtask

  task automatic do_reset(output int k);
    reset = 1'b1;
    stage_ready = 4'h0;
    for (int i = 0; i < NS; i++) rise[i] = -1;
    expect_at(cyc + 1, 4'hF, 1'b0, 1'b0, 2'd0);
    repeat (3) tick();
    mon_en = 1'b1;
    checks++;
    if (stage_rst !== 4'hF || seq_done !== 1'b0 ||
        seq_error !== 1'b0 || err_stage !== 2'd0) begin
      failures++;
      $display("FAIL reset_state got rst=%b done=%b err=%b es=%0d exp rst=1111 done=0 err=0 es=0",
               stage_rst, seq_done, seq_error, err_stage);
    end
    reset = 1'b0;
    k = cyc + 1;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL %s pending=%0d next_edge=%0d now=%0d", name, q.size(), q[0].e, cyc);
      q.delete();
    end
  endtask

  task automatic drop_in_done(input int fin, input logic [3:0] mask);
    int m;
    logic [1:0] low;
    m = $urandom_range(1, 5);
    low = 2'd0;
    for (int i = NS - 1; i >= 0; i--) if (mask[i]) low = 2'(i);
    run_to(fin + m);
    stage_ready = stage_ready & ~mask;
    expect_at(cyc + 1, 4'hF, 1'b0, 1'b1, low);
    run_to(cyc + 5);
  endtask

  initial begin
    int k;
    int fin;
    int p;
    int dd[NS];

    do_reset(k);
    dd = '{3, 3, 3, 3};
    plan(k, dd, BIG, fin);
    run_to(fin + 5);
    check_drained("nominal");

    repeat (3) begin
      do_reset(k);
      for (int i = 0; i < NS; i++) dd[i] = $urandom_range(1, 40);
      plan(k, dd, BIG, fin);
      drop_in_done(fin, 4'($urandom_range(1, 15)));
      check_drained("random_drop");
    end

    do_reset(k);
    dd = '{3, 3, NEVER, 3};
    plan(k, dd, BIG, fin);
    run_to(fin + 5);
    check_drained("timeout");
    stage_ready = 4'hF;
    run_to(cyc + 20);
    check_drained("error_terminal");

    do_reset(k);
    dd = '{2, T, 3, 4};
    plan(k, dd, BIG, fin);
    run_to(fin + 5);
    check_drained("ready_on_last_cycle");

    do_reset(k);
    dd = '{3, NEVER, 3, 3};
    p = k + 2 * (G + 1) + 3 + 6;
    plan(k, dd, p, fin);
    run_to(p - 1);
    reset = 1'b1;
    stage_ready = 4'h0;
    for (int i = 0; i < NS; i++) rise[i] = -1;
    expect_at(p, 4'hF, 1'b0, 1'b0, 2'd0);
    tick();
    reset = 1'b0;
    k = cyc + 1;
    for (int i = 0; i < NS; i++) dd[i] = $urandom_range(1, 20);
    plan(k, dd, BIG, fin);
    run_to(fin + 5);
    check_drained("reset_pulse");

    do_reset(k);
    stage_ready = 4'hF;
    dd = '{1, 1, 1, 1};
    plan(k, dd, BIG, fin);
    drop_in_done(fin, 4'b1000);
    check_drained("all_ready_then_drop3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
